// File: rtl/comp_pkg.sv
// Shared constants and types for the 256-bit popcount compressor / thermometer expander pair.
package comp_pkg;

    localparam int N     = 256;
    localparam int CW    = $clog2(N + 1);
    localparam int OUT_W = 64;
    localparam int BEATS = N / OUT_W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } therm_state_t;

    typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/therm_beat.sv
// Combinational slice of a thermometer column: bit j is set iff its absolute
// position idx*OUT_W + j lies below cnt. Positions are compared one bit wider than cnt so nothing wraps.
module therm_beat #(
    parameter int CW    = 9,
    parameter int OUT_W = 64,
    parameter int IW    = 2
) (
    input  logic [CW-1:0]    cnt,
    input  logic [IW-1:0]    idx,
    output logic [OUT_W-1:0] beat
);

    localparam int PW = CW + 1;

    logic [PW-1:0] pos;

    always_comb begin
        beat = '0;
        pos  = '0;
        for (int j = 0; j < OUT_W; j++) begin
            pos     = PW'(idx) * PW'(OUT_W) + PW'(j);
            beat[j] = (pos < {1'b0, cnt});
        end
    end

endmodule

// File: rtl/therm_expand256.sv
// Count-to-thermometer expander: accepts a count and streams a 256-bit column LSB-first in OUT_W-bit beats.
// Define THERM_BACK2BACK_EN to accept the next count during the final beat handshake (no bubble between columns).
module therm_expand256
    import comp_pkg::*;
#(
    parameter int N     = comp_pkg::N,
    parameter int CW    = comp_pkg::CW,
    parameter int OUT_W = comp_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW-1:0]    cnt_in,
    input  logic             cnt_valid,
    output logic             cnt_ready,
    output logic [OUT_W-1:0] col_out,
    output logic             col_valid,
    input  logic             col_ready,
    output logic             col_last,
    output logic             sat_err
);

    localparam int BEATS = N / OUT_W;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Both streams use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; a producer holds valid and its payload stable until that transfer.

    therm_state_t     state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             cnt_ready_q, cnt_ready_d;
    logic             col_valid_q, col_valid_d;
    logic             col_last_q, col_last_d;
    logic [OUT_W-1:0] col_out_q, col_out_d;
    logic [OUT_W-1:0] beat;
    logic             load;
    logic             beat_hs;
    logic             over;
    logic             last_beat;

`ifdef THERM_BACK2BACK_EN
    // Ready opens combinationally while the final beat is being taken, so a new count can chain on.
    assign cnt_ready = cnt_ready_q | (col_last_q & col_ready);
`else
    assign cnt_ready = cnt_ready_q;
`endif

    assign load      = cnt_valid & cnt_ready;
    assign beat_hs   = col_valid_q & col_ready;
    assign over      = ({1'b0, cnt_in} > (CW + 1)'(N));
    assign last_beat = (idx_q == IW'(BEATS - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        col_valid_d = col_valid_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d     = EMIT;
                    idx_d       = '0;
                    cnt_d       = over ? CW'(N) : cnt_in;
                    sat_d       = sat_q | over;
                    col_valid_d = 1'b1;
                end
            end
            EMIT: begin
                if (beat_hs) begin
                    if (!last_beat) begin
                        idx_d = idx_q + IW'(1);
                    end else if (load) begin
                        idx_d = '0;
                        cnt_d = over ? CW'(N) : cnt_in;
                        sat_d = sat_q | over;
                    end else begin
                        state_d     = IDLE;
                        col_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                col_valid_d = 1'b0;
            end
        endcase
        cnt_ready_d = (state_d == IDLE);
        col_last_d  = col_valid_d && (idx_d == IW'(BEATS - 1));
        col_out_d   = col_valid_d ? beat : '0;
    end

    // Beat is computed from next-state count/index so col_out is a plain register.
    therm_beat #(
        .CW    (CW),
        .OUT_W (OUT_W),
        .IW    (IW)
    ) u_beat (
        .cnt  (cnt_d),
        .idx  (idx_d),
        .beat (beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            cnt_ready_q <= 1'b0;
            col_valid_q <= 1'b0;
            col_last_q  <= 1'b0;
            col_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            cnt_ready_q <= cnt_ready_d;
            col_valid_q <= col_valid_d;
            col_last_q  <= col_last_d;
            col_out_q   <= col_out_d;
        end
    end

    assign col_out   = col_out_q;
    assign col_valid = col_valid_q;
    assign col_last  = col_last_q;
    assign sat_err   = sat_q;

endmodule
